// File: rtl/redmule_streamout_serializer_if.sv
// Request/grant bus used on both sides of the store serialiser:
// the wide Z beat stream on the way in and the TCDM write port on the way out.
interface redmule_streamout_serializer_if #(
  parameter int DW = 64,
  parameter int AW = 32
);
  logic            req;
  logic            gnt;
  logic [AW-1:0]   add;
  logic            wen;
  logic [DW/8-1:0] be;
  logic [DW-1:0]   data;

  modport master (output req, add, wen, be, data, input gnt);
  modport slave  (input req, add, be, data, output gnt);
endinterface

// File: rtl/redmule_streamout_serializer.sv
// Store-side beat FIFO plus wide-to-narrow serialiser for the RedMulE Z stream.
// Sub-beats with all-zero strobes are skipped; flush/done and a grant counter face the controller.
module redmule_streamout_serializer #(
  parameter int IN_DW      = 256,
  parameter int OUT_DW     = 64,
  parameter int AW         = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        enable_i,
  redmule_streamout_serializer_if.slave  in_s,
  redmule_streamout_serializer_if.master out_m,
  input  logic        flush_i,
  output logic        done_o,
  output logic        idle_o,
  output logic        fifo_full_o,
  output logic        fifo_empty_o,
  output logic [31:0] wr_count_o
);
  localparam int RATIO = IN_DW / OUT_DW;
  localparam int BE    = OUT_DW / 8;
  localparam int IBE   = IN_DW / 8;
  localparam int IW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [IN_DW-1:0] r_data [FIFO_DEPTH];
  logic [IBE-1:0]   r_strb [FIFO_DEPTH];
  logic [AW-1:0]    r_addr [FIFO_DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_cnt;
  logic [0:0]       r_state;
  logic [IW-1:0]    r_idx;
  logic             r_flush;
  logic [31:0]      r_wcnt;

  logic [IN_DW-1:0] w_hdata;
  logic [IBE-1:0]   w_hstrb;
  logic [AW-1:0]    w_hadd;
  logic [RATIO-1:0] w_nz;
  logic [IW-1:0]    w_act;
  logic             w_any, w_nxt_any;
  logic             w_full, w_empty, w_push, w_pop, w_req, w_fire, w_idle, w_done;

  assign w_full  = (r_cnt == CW'(FIFO_DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_push  = in_s.req & ~w_full;
  assign w_hdata = r_data[r_rptr];
  assign w_hstrb = r_strb[r_rptr];
  assign w_hadd  = r_addr[r_rptr];

  // Active sub-beat is the lowest nonzero-strobe slice at or above r_idx,
  // so empty slices cost no cycles.
  always_comb begin
    w_nz      = '0;
    w_act     = '0;
    w_any     = 1'b0;
    w_nxt_any = 1'b0;
    for (int k = 0; k < RATIO; k++) w_nz[k] = |w_hstrb[k*BE +: BE];
    for (int k = RATIO-1; k >= 0; k--)
      if (w_nz[k] && (IW'(k) >= r_idx)) begin
        w_act = IW'(k);
        w_any = 1'b1;
      end
    for (int k = 0; k < RATIO; k++)
      if (w_nz[k] && (IW'(k) > w_act)) w_nxt_any = 1'b1;
  end

  // Request rises combinationally from IDLE, which also gives bubble-free
  // hand-over from one beat to the next without looking past the head.
  assign w_req  = (r_state == ST_SEND) | (~w_empty & w_any & enable_i);
  assign w_fire = w_req & out_m.gnt;
  assign w_pop  = (w_fire & ~w_nxt_any) |
                  ((r_state == ST_IDLE) & ~w_empty & ~w_any);
  assign w_idle = w_empty & (r_state == ST_IDLE);
  assign w_done = r_flush & w_idle & ~w_push;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_data[r_wptr] <= in_s.data;
      r_strb[r_wptr] <= in_s.be;
      r_addr[r_wptr] <= in_s.add;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_flush <= 1'b0;
      r_wcnt  <= '0;
    end else if (clear_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_flush <= 1'b0;
      r_wcnt  <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PW'(FIFO_DEPTH-1)) ? '0 : r_wptr + PW'(1);
      if (w_pop)  r_rptr <= (r_rptr == PW'(FIFO_DEPTH-1)) ? '0 : r_rptr + PW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      if (w_fire) begin
        r_wcnt <= r_wcnt + 32'd1;
        if (w_nxt_any) begin
          r_idx   <= w_act + IW'(1);
          r_state <= ST_SEND;
        end else begin
          r_idx   <= '0;
          r_state <= ST_IDLE;
        end
      end else if (w_req) begin
        r_state <= ST_SEND;
      end
      if (w_done)       r_flush <= 1'b0;
      else if (flush_i) r_flush <= 1'b1;
    end
  end

  assign in_s.gnt     = ~w_full;
  assign out_m.req    = w_req;
  assign out_m.add    = w_hadd + AW'(w_act) * AW'(BE);
  assign out_m.wen    = 1'b0;
  assign out_m.be     = w_hstrb[w_act*BE +: BE];
  assign out_m.data   = w_hdata[w_act*OUT_DW +: OUT_DW];
  assign done_o       = w_done;
  assign idle_o       = w_idle;
  assign fifo_full_o  = w_full;
  assign fifo_empty_o = w_empty;
  assign wr_count_o   = r_wcnt;
endmodule

// File: tb/tb_redmule_streamout_serializer.sv
// Directed bench for the store serialiser at IN_DW=256, OUT_DW=64 (RATIO=4), depth 2.
module tb_redmule_streamout_serializer;
  localparam logic [63:0] S0 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] S1 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] S2 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] S3 = 64'h4444_4444_4444_4444;

  logic        clk_i = 1'b0;
  logic        rst_ni, clear_i, enable_i, flush_i;
  logic        done_o, idle_o, fifo_full_o, fifo_empty_o;
  logic [31:0] wr_count_o;
  logic [255:0] dat;
  int n_chk = 0;
  int n_err = 0;

  redmule_streamout_serializer_if #(.DW(256), .AW(32)) in_if ();
  redmule_streamout_serializer_if #(.DW(64),  .AW(32)) out_if ();

  redmule_streamout_serializer #(.IN_DW(256), .OUT_DW(64), .AW(32), .FIFO_DEPTH(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i),
    .in_s(in_if), .out_m(out_if), .flush_i(flush_i), .done_o(done_o), .idle_o(idle_o),
    .fifo_full_o(fifo_full_o), .fifo_empty_o(fifo_empty_o), .wr_count_o(wr_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic push(input logic [31:0] strb, input logic [31:0] addr);
    in_if.req = 1'b1; in_if.be = strb; in_if.add = addr; in_if.data = dat;
  endtask

  task automatic chk_req(input string tag, input logic [31:0] add, input logic [7:0] be,
                         input logic [63:0] d);
    chk({tag, "_req"}, out_if.req, 1'b1);
    chk({tag, "_add"}, out_if.add, add);
    chk({tag, "_be"},  out_if.be, be);
    chk({tag, "_data"}, out_if.data, d);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_req"},   out_if.req, 1'b0);
    chk({tag, "_rdy"},   in_if.gnt, 1'b1);
    chk({tag, "_idle"},  idle_o, 1'b1);
    chk({tag, "_empty"}, fifo_empty_o, 1'b1);
    chk({tag, "_full"},  fifo_full_o, 1'b0);
    chk({tag, "_done"},  done_o, 1'b0);
    chk({tag, "_cnt"},   wr_count_o, 32'd0);
    chk({tag, "_wen"},   out_if.wen, 1'b0);
  endtask

  initial begin
    dat = {S3, S2, S1, S0};
    rst_ni = 1'b0; clear_i = 1'b0; enable_i = 1'b1; flush_i = 1'b0;
    in_if.req = 1'b0; in_if.wen = 1'b0; in_if.be = '0; in_if.add = '0; in_if.data = '0;
    out_if.gnt = 1'b1;
    smp(); chk_rst("reset");
    tick(); tick(); rst_ni = 1'b1; tick();

    // full beat, grant tied high: 4 consecutive requests starting one cycle after the push
    push(32'hFFFF_FFFF, 32'h1000);
    smp(); chk("t1_lat", out_if.req, 1'b0);
    tick(); in_if.req = 1'b0;
    smp(); chk_req("t1_k0", 32'h1000, 8'hFF, S0); tick();
    smp(); chk_req("t1_k1", 32'h1008, 8'hFF, S1); tick();
    smp(); chk_req("t1_k2", 32'h1010, 8'hFF, S2); tick();
    smp(); chk_req("t1_k3", 32'h1018, 8'hFF, S3); tick();
    smp(); chk("t1_end_req", out_if.req, 1'b0); chk("t1_cnt", wr_count_o, 32'd4);
    chk("t1_idle", idle_o, 1'b1);
    tick();

    // sparse strobe: only slices 1 and 3 carry data
    push(32'h0F00_FF00, 32'h2000);
    tick(); in_if.req = 1'b0;
    smp(); chk_req("t2_k1", 32'h2008, 8'hFF, S1); tick();
    smp(); chk_req("t2_k3", 32'h2018, 8'h0F, S3); tick();
    smp(); chk("t2_end_req", out_if.req, 1'b0); chk("t2_cnt", wr_count_o, 32'd6);
    tick();

    // all-zero beat is dropped, the following full beat starts right after
    push(32'h0000_0000, 32'h3000);
    tick(); push(32'hFFFF_FFFF, 32'h4000);
    smp(); chk("t3_zero_req", out_if.req, 1'b0);
    tick(); in_if.req = 1'b0;
    smp(); chk_req("t3_k0", 32'h4000, 8'hFF, S0); tick();
    smp(); chk_req("t3_k1", 32'h4008, 8'hFF, S1); tick();
    smp(); chk_req("t3_k2", 32'h4010, 8'hFF, S2); tick();
    smp(); chk_req("t3_k3", 32'h4018, 8'hFF, S3); tick();
    smp(); chk("t3_end_req", out_if.req, 1'b0); chk("t3_cnt", wr_count_o, 32'd10);
    tick();

    // grant stall for 5 cycles, FIFO fills, nothing lost afterwards
    out_if.gnt = 1'b0;
    push(32'hFFFF_FFFF, 32'h5000);
    tick(); push(32'hFFFF_FFFF, 32'h6000);
    for (int i = 0; i < 5; i++) begin
      smp(); chk_req("t4_stall", 32'h5000, 8'hFF, S0);
      tick(); in_if.req = 1'b0;
    end
    out_if.gnt = 1'b1;
    smp(); chk("t4_rdy_full", in_if.gnt, 1'b0); chk("t4_full", fifo_full_o, 1'b1);
    chk_req("t4_a0", 32'h5000, 8'hFF, S0); tick();
    smp(); chk_req("t4_a1", 32'h5008, 8'hFF, S1); tick();
    smp(); chk_req("t4_a2", 32'h5010, 8'hFF, S2); tick();
    smp(); chk_req("t4_a3", 32'h5018, 8'hFF, S3); chk("t4_rdy_pop", in_if.gnt, 1'b0); tick();
    smp(); chk_req("t4_b0", 32'h6000, 8'hFF, S0); chk("t4_rdy_after", in_if.gnt, 1'b1); tick();
    smp(); chk_req("t4_b1", 32'h6008, 8'hFF, S1); tick();
    smp(); chk_req("t4_b2", 32'h6010, 8'hFF, S2); tick();
    smp(); chk_req("t4_b3", 32'h6018, 8'hFF, S3); tick();
    smp(); chk("t4_end_req", out_if.req, 1'b0); chk("t4_cnt", wr_count_o, 32'd18);
    tick();

    // flush with two beats queued, then flush while empty
    out_if.gnt = 1'b0;
    push(32'h0000_00FF, 32'h7000);
    tick(); push(32'hFF00_0000, 32'h7100);
    smp(); chk_req("t5_x_wait", 32'h7000, 8'hFF, S0);
    tick(); in_if.req = 1'b0; out_if.gnt = 1'b1; flush_i = 1'b1;
    smp(); chk("t5_done_a", done_o, 1'b0); chk_req("t5_x", 32'h7000, 8'hFF, S0);
    tick(); flush_i = 1'b0;
    smp(); chk("t5_done_b", done_o, 1'b0); chk_req("t5_y", 32'h7118, 8'hFF, S3);
    tick();
    smp(); chk("t5_done_c", done_o, 1'b1); chk("t5_cnt", wr_count_o, 32'd20);
    tick();
    smp(); chk("t5_done_d", done_o, 1'b0);
    tick(); flush_i = 1'b1;
    smp(); chk("t5_done_e", done_o, 1'b0);
    tick(); flush_i = 1'b0;
    smp(); chk("t5_done_f", done_o, 1'b1);
    tick();
    smp(); chk("t5_done_g", done_o, 1'b0);
    tick();

    // async reset while a request is stalled
    out_if.gnt = 1'b0;
    push(32'hFFFF_FFFF, 32'h7800);
    tick(); in_if.req = 1'b0;
    smp(); chk("t6_pre_req", out_if.req, 1'b1);
    tick(); rst_ni = 1'b0;
    smp(); chk_rst("t6_rst");
    tick(); rst_ni = 1'b1; tick();

    // enable gating, request held with enable low, then clear with FIFO full and flush pending
    enable_i = 1'b0;
    push(32'hFFFF_FFFF, 32'h8000);
    tick(); push(32'hFFFF_FFFF, 32'h9000);
    smp(); chk("t7_en_low", out_if.req, 1'b0);
    tick(); in_if.req = 1'b0; enable_i = 1'b1; out_if.gnt = 1'b1; flush_i = 1'b1;
    smp(); chk_req("t7_k0", 32'h8000, 8'hFF, S0); chk("t7_full", fifo_full_o, 1'b1);
    tick(); enable_i = 1'b0; out_if.gnt = 1'b0; flush_i = 1'b0; clear_i = 1'b1;
    smp(); chk_req("t7_hold", 32'h8008, 8'hFF, S1); chk("t7_cnt", wr_count_o, 32'd1);
    tick(); clear_i = 1'b0; enable_i = 1'b1;
    smp(); chk_rst("t7_clr");
    tick();
    smp(); chk("t7_after_req", out_if.req, 1'b0); chk("t7_after_done", done_o, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
